// File: rtl/one_to_eight_demux.sv
// one_to_eight_demux: registered 1-to-8 demux, one valid/ready slot per channel.
// Define DEMUX_RR_EN to ignore in_sel and route round-robin via rr_ptr.
module one_to_eight_demux #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [2:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [8*WIDTH-1:0] out_data,
    output logic [7:0]         out_valid,
    input  logic [7:0]         out_ready
);
    logic [2:0]            target;
    logic                  push;
    logic [7:0][WIDTH-1:0] slot;
`ifdef DEMUX_RR_EN
    logic [2:0] rr_ptr;
    logic       unused_sel;
    assign unused_sel = ^in_sel;
    assign target     = rr_ptr;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)    rr_ptr <= '0;
        else if (push) rr_ptr <= rr_ptr + 3'd1;
`else
    assign target = in_sel;
`endif
    // a draining slot can be refilled in the same cycle
    assign in_ready = ~out_valid[target] | out_ready[target];
    assign push     = in_valid & in_ready;
    assign out_data = slot;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            slot      <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (push && target == 3'(i)) begin
                    slot[i]      <= in_data;
                    out_valid[i] <= 1'b1;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end
endmodule
